// File: rtl/moore_101_framer_tx.sv
// Serial "101"-preamble framing transmitter: preamble, payload MSB-first, optional parity, idle gap.
// Optional even-parity bit is enabled by defining MOORE_101_FRAMER_TX_PARITY_EN.
module moore_101_framer_tx #(
    parameter int DATA_W = 8,
    parameter int GAP    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              dout,
    output logic              dout_en,
    output logic              frame_done
);

    localparam int MAX_CNT = (DATA_W > GAP) ? ((DATA_W > 3) ? DATA_W : 3)
                                            : ((GAP > 3) ? GAP : 3);
    localparam int CNT_W   = $clog2(MAX_CNT);

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(2);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_DATA = 3'd2,
        S_PAR  = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    localparam state_t POST_STATE = (GAP > 0) ? S_GAP : S_IDLE;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  sreg_q, sreg_d;
    logic               dout_q, dout_d;
    logic               dout_en_q, dout_en_d;
    logic               in_ready_q, in_ready_d;
    logic               frame_done_q, frame_done_d;
    logic               accept;
`ifdef MOORE_101_FRAMER_TX_PARITY_EN
    logic               par_q, par_d;
`endif

    assign accept = in_valid && in_ready_q;

    // NOTE: every signal written here gets a default first, otherwise a path that skips it infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_PRE;
                    cnt_d   = PRE_LAST;
                    sreg_d  = in_data;
                end
            end
            S_PRE: begin
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                    cnt_d   = DATA_LAST;
                end
            end
            S_DATA: begin
                sreg_d = sreg_q << 1;
                if (cnt_q == '0) begin
`ifdef MOORE_101_FRAMER_TX_PARITY_EN
                    state_d = S_PAR;
                    cnt_d   = '0;
`else
                    state_d = POST_STATE;
                    cnt_d   = GAP_LAST;
`endif
                end
            end
`ifdef MOORE_101_FRAMER_TX_PARITY_EN
            S_PAR: begin
                state_d = POST_STATE;
                cnt_d   = GAP_LAST;
            end
`endif
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef MOORE_101_FRAMER_TX_PARITY_EN
    // Parity is captured with the word, since the shift register destroys it.
    assign par_d = accept ? ^in_data : par_q;
`endif

    // Outputs are decoded from the next state so they come straight out of flops.
    always_comb begin
        dout_d       = 1'b0;
        dout_en_d    = 1'b0;
        in_ready_d   = (state_d == S_IDLE);
        frame_done_d = (state_q != S_IDLE) && (state_d == S_IDLE);
        case (state_d)
            S_PRE: begin
                dout_d    = ~cnt_d[0];
                dout_en_d = 1'b1;
            end
            S_DATA: begin
                dout_d    = sreg_d[DATA_W-1];
                dout_en_d = 1'b1;
            end
`ifdef MOORE_101_FRAMER_TX_PARITY_EN
            S_PAR: begin
                dout_d    = par_d;
                dout_en_d = 1'b1;
            end
`endif
            default: begin
                dout_d    = 1'b0;
                dout_en_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sreg_q       <= '0;
            dout_q       <= 1'b0;
            dout_en_q    <= 1'b0;
            in_ready_q   <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef MOORE_101_FRAMER_TX_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sreg_q       <= sreg_d;
            dout_q       <= dout_d;
            dout_en_q    <= dout_en_d;
            in_ready_q   <= in_ready_d;
            frame_done_q <= frame_done_d;
`ifdef MOORE_101_FRAMER_TX_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_en    = dout_en_q;
    assign in_ready   = in_ready_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_moore_101_framer_tx.sv
// Bench for moore_101_framer_tx: cycle model + expected-bit queue for an 8-bit/GAP=1 instance,
// directed checks for a 1-bit/GAP=0 instance.
module tb_moore_101_framer_tx;

    localparam int DW = 8;
    localparam int GP = 1;
`ifdef MOORE_101_FRAMER_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int PERIOD = 1 + 3 + DW + P + GP;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, dout, dout_en, frame_done;

    logic          in_valid2 = 1'b0;
    logic [0:0]    in_data2 = '0;
    logic          in_ready2, dout2, dout_en2, frame_done2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    moore_101_framer_tx #(.DATA_W(DW), .GAP(GP)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .dout(dout), .dout_en(dout_en), .frame_done(frame_done)
    );

    moore_101_framer_tx #(.DATA_W(1), .GAP(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .dout(dout2), .dout_en(dout_en2), .frame_done(frame_done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: ready/done timing from a frame-length countdown, line bits queued at accept.
    logic [1:0] exp_q[$];
    int         m_cnt;
    logic       m_ready, m_done;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt   <= 0;
            m_ready <= 1'b0;
            m_done  <= 1'b0;
            exp_q.delete();
        end else begin
            m_done <= (m_cnt == 1);
            if (m_cnt != 0) begin
                m_cnt   <= m_cnt - 1;
                m_ready <= (m_cnt == 1);
            end else if (m_ready && in_valid) begin
                m_cnt   <= PERIOD - 1;
                m_ready <= 1'b0;
                exp_q.push_back(2'b11);
                exp_q.push_back(2'b10);
                exp_q.push_back(2'b11);
                for (int i = DW - 1; i >= 0; i--) exp_q.push_back({1'b1, in_data[i]});
                if (P == 1) exp_q.push_back({1'b1, ^in_data});
                for (int i = 0; i < GP; i++) exp_q.push_back(2'b00);
            end else begin
                m_ready <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin : monitor
        logic [1:0] e;
        e = 2'b00;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        check($sformatf("in_ready@%0d", cyc), in_ready, m_ready);
        check($sformatf("frame_done@%0d", cyc), frame_done, m_done);
        check($sformatf("dout_en@%0d", cyc), dout_en, e[1]);
        check($sformatf("dout@%0d", cyc), dout, e[0]);
    end

    task automatic send_one(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~d;
        repeat (PERIOD + 2) @(negedge clk);
    endtask

    logic b2 [1:5];

    initial begin
        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        check("rst dout", dout, 1'b0);
        check("rst dout_en", dout_en, 1'b0);
        check("rst in_ready", in_ready, 1'b0);
        check("rst frame_done", frame_done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready after release", in_ready, 1'b1);
        check("ready2 after release", in_ready2, 1'b1);

        // Single frames (parity of 8'h07 is 1, of 8'hA5 is 0).
        send_one(8'hA5);
        send_one(8'h07);

        // Back-to-back with in_valid held high.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(negedge clk);
        in_data  = 8'h00;
        repeat (PERIOD) @(negedge clk);
        in_valid = 1'b0;
        repeat (PERIOD + 2) @(negedge clk);

        // Hold-off: source wiggles while a frame is in flight.
        in_valid = 1'b1;
        in_data  = 8'h3C;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 2; c <= 10; c++) begin
            @(negedge clk);
            in_valid = c[0];
            in_data  = DW'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (PERIOD + 2) @(negedge clk);

        // Asynchronous reset in the middle of the data field, between clock edges.
        in_valid = 1'b1;
        in_data  = 8'h5A;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("pre-abort dout_en", dout_en, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort dout", dout, 1'b0);
        check("abort dout_en", dout_en, 1'b0);
        check("abort in_ready", in_ready, 1'b0);
        check("abort frame_done", frame_done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (PERIOD + 2) @(negedge clk);

        // DATA_W=1, GAP=0 instance: 1,0,1,1 (+ parity 1) then straight to IDLE.
        b2[1] = 1'b1; b2[2] = 1'b0; b2[3] = 1'b1; b2[4] = 1'b1; b2[5] = 1'b1;
        check("w1 ready", in_ready2, 1'b1);
        in_valid2 = 1'b1;
        in_data2  = 1'b1;
        for (int k = 1; k <= 4 + P; k++) begin
            @(negedge clk);
            check($sformatf("w1 dout_en c%0d", k), dout_en2, 1'b1);
            check($sformatf("w1 dout c%0d", k), dout2, b2[k]);
            check($sformatf("w1 ready c%0d", k), in_ready2, 1'b0);
        end
        @(negedge clk);
        check("w1 frame_done", frame_done2, 1'b1);
        check("w1 ready at done", in_ready2, 1'b1);
        check("w1 dout_en at done", dout_en2, 1'b0);
        @(negedge clk);
        in_valid2 = 1'b0;
        check("w1 re-accept dout_en", dout_en2, 1'b1);
        check("w1 re-accept dout", dout2, 1'b1);
        check("w1 frame_done clears", frame_done2, 1'b0);
        repeat (8) @(negedge clk);
        check("w1 idle ready", in_ready2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/moore_101_framer_tx.md
# moore_101_framer_tx

Serial framing transmitter that drives the single-bit line consumed by the team's "101" sequence detectors. It accepts a parallel word over a valid/ready handshake and shifts out a fixed "101" preamble followed by the word MSB-first. An optional parity bit and a programmable idle gap follow the word. All serial outputs are registered Moore outputs, decoded from state and shift register only, so the line is glitch-free for the downstream detector.

## Interface
- DATA_W, 8, payload width in bits; legal range 1..32
- GAP, 1, number of idle-zero cycles after each frame; legal range 0..15
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  source offers in_data
- in_ready  output  1  block can accept a word this cycle
- in_data  input  DATA_W  payload word, sampled on the accept edge
- dout  output  1  serial line
- dout_en  output  1  high while dout carries a preamble, data, or parity bit
- frame_done  output  1  one-cycle pulse when a frame, including its gap, is complete

## Operation
- States:
  - IDLE
  - PRE: 3 cycles, bits 1,0,1
  - DATA: DATA_W cycles
  - PAR: 1 cycle, present only with the configuration macro
  - GAP: GAP cycles
- Accept: the rising edge where in_valid && in_ready captures in_data into the shift register and moves IDLE→PRE. in_valid without in_ready is ignored; the source holds its data.
- Transitions:
  - PRE→DATA after the 3rd preamble bit.
  - DATA→PAR or GAP after bit 0.
  - PAR→GAP.
  - GAP→IDLE after GAP cycles.
  - If GAP=0, the last bit goes directly to IDLE.
- dout per state:
  - PRE: preamble bit.
  - DATA: shift register MSB, shifting left each cycle.
  - PAR: parity bit.
  - IDLE and GAP: 0.
- dout_en = 1 in PRE, DATA and PAR only.
- in_ready is registered. It is 1 in every IDLE cycle, 0 otherwise.
- frame_done is registered. It is 1 in the first IDLE cycle after a frame.
- in_data changes after the accept edge have no effect on the frame in flight.
- A single bit counter sized for max(3, DATA_W, GAP) is reloaded on every state entry. It has no wrap-around beyond the terminal count.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, dout=0, dout_en=0, in_ready=0, frame_done=0, shift register 0.
- in_ready rises on the first clk edge after rst_n deasserts.
- Reset mid-frame: outputs drop to their reset values immediately, the frame is abandoned, and no frame_done is produced.
- Latency, with accept edge = cycle 0:
  - Preamble on cycles 1–3.
  - Data bit DATA_W-1 on cycle 4; bit 0 on cycle 3+DATA_W.
  - Parity, if enabled, on cycle 4+DATA_W.
  - Gap follows the last bit.
- Frame period: 1 + 3 + DATA_W + P + GAP cycles, where P = 1 with parity, else 0. With in_valid held high, frames run back-to-back at this period with one IDLE cycle between them.
- Simultaneous frame_done and accept: legal in the same IDLE cycle.

## Configuration
- MOORE_101_FRAMER_TX_PARITY_EN defined: the PAR state exists and appends one even-parity bit, the XOR of all DATA_W payload bits, with dout_en=1.
- Macro undefined: no PAR state; DATA goes directly to GAP or IDLE. P = 0 in all timing formulas.

## Test plan
- Reset: hold rst_n low for 3 cycles → dout=0, dout_en=0, in_ready=0, frame_done=0. in_ready=1 one cycle after release. Assert rst_n mid-clock → outputs clear without a clock edge.
- Single frame, DATA_W=8, GAP=1, no parity, in_data=8'hA5:
  - Cycles 1–11: dout 1,0,1,1,0,1,0,0,1,0,1, dout_en=1.
  - Cycle 12: dout=0, dout_en=0.
  - Cycle 13: frame_done=1, in_ready=1.
- Back-to-back: in_valid held high with 8'hFF then 8'h00 → second accept in cycle 13 and its preamble starting at cycle 14. Period 13 cycles. in_ready low in cycles 1–12.
- Hold-off: toggle in_valid and in_data during cycles 2–10 of an 8'h3C frame → data bits stay 0,0,1,1,1,1,0,0, with no extra accepts.
- Parity (macro defined), in_data=8'h07:
  - Cycle 12: dout=1, dout_en=1.
  - Period 14 cycles.
  - With 8'hA5 the parity bit is 0.
- GAP=0, DATA_W=1, in_data=1'b1 → dout 1,0,1,1 on cycles 1–4, frame_done at cycle 5, next accept possible at cycle 5.
